// File: rtl/join2_pkg.sv
// Shared types and helpers for the two-branch buffered join.
// The stats struct is consumed only when JOIN2_BUFFERED_STATS_EN is defined.
package join2_pkg;

    localparam int STALL_W    = 32;
    localparam int SKEW_W_MAX = 8;

    typedef logic [STALL_W-1:0]    stall_cnt_t;
    typedef logic [SKEW_W_MAX-1:0] wide_count_t;

    typedef struct packed {
        wide_count_t skew_max;
        stall_cnt_t  stall_cycles;
    } join2_stats_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/join2_fifo.sv
// Single-branch synchronous FIFO with a combinational head read and an occupancy count.
module join2_fifo
    import join2_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int AW         = addr_w(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/join2_buffered.sv
// Rejoins two independently timed branch streams into one registered {branch1, branch0} stream.
// Define JOIN2_BUFFERED_STATS_EN to add the skew_max and stall_cycles observation outputs.
module join2_buffered
    import join2_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int CW         = addr_w(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in_0,
    input  logic [DATA_WIDTH-1:0]   data_in_1,
    input  logic [1:0]              data_in_valid,
    output logic [1:0]              data_in_ready,
    output logic [2*DATA_WIDTH-1:0] data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready
`ifdef JOIN2_BUFFERED_STATS_EN
    ,
    output logic [CW-1:0]           skew_max,
    output logic [STALL_W-1:0]      stall_cycles
`endif
);

    logic [DATA_WIDTH-1:0]   head_0, head_1;
    logic [CW-1:0]           count_0, count_1;
    logic                    full_0, full_1;
    logic                    empty_0, empty_1;
    logic                    push_0, push_1;
    logic                    load;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    // Ready is derived purely from registered occupancy, never from valid or downstream ready.
    assign data_in_ready[0] = (count_0 != CW'(DEPTH));
    assign data_in_ready[1] = (count_1 != CW'(DEPTH));
    assign push_0 = data_in_valid[0] && !full_0;
    assign push_1 = data_in_valid[1] && !full_1;
    assign load   = !empty_0 && !empty_1 && (!out_valid_q || data_out_ready);

    join2_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_0),
        .pop   (load),
        .wdata (data_in_0),
        .rdata (head_0),
        .count (count_0),
        .full  (full_0),
        .empty (empty_0)
    );

    join2_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_1),
        .pop   (load),
        .wdata (data_in_1),
        .rdata (head_1),
        .count (count_1),
        .full  (full_1),
        .empty (empty_1)
    );

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = {head_1, head_0};
            out_valid_d = 1'b1;
        end else if (data_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out       = out_data_q;
    assign data_out_valid = out_valid_q;

`ifdef JOIN2_BUFFERED_STATS_EN
    join2_stats_t stats_q, stats_d;
    wide_count_t  wide_0, wide_1, skew_now;

    always_comb begin
        stats_d  = stats_q;
        wide_0   = wide_count_t'(count_0);
        wide_1   = wide_count_t'(count_1);
        skew_now = (wide_0 > wide_1) ? (wide_0 - wide_1) : (wide_1 - wide_0);
        if (skew_now > stats_q.skew_max) begin
            stats_d.skew_max = skew_now;
        end
        // Stall counter sticks at all-ones rather than wrapping.
        if (out_valid_q && !data_out_ready && (stats_q.stall_cycles != '1)) begin
            stats_d.stall_cycles = stats_q.stall_cycles + stall_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign skew_max     = stats_q.skew_max[CW-1:0];
    assign stall_cycles = stats_q.stall_cycles;
`endif

endmodule

// File: tb/tb_join2_buffered.sv
// Scoreboard bench for join2_buffered: directed scenarios plus random valid/ready traffic.
// Stats checks are compiled in only when JOIN2_BUFFERED_STATS_EN is defined.
module tb_join2_buffered;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [DW-1:0] dIn0   = '0;
    logic [DW-1:0] dIn1   = '0;
    logic [1:0]    vIn    = '0;
    logic [1:0]    rdy;
    logic [2*DW-1:0] dOut;
    logic          vOut;
    logic          outRdy = 1'b0;
`ifdef JOIN2_BUFFERED_STATS_EN
    logic [2:0]    skewMax;
    logic [31:0]   stallCycles;
`endif

    int            nCompared   = 0;
    int            nMismatched = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            acc0, acc1, prevStall;
    logic [2*DW-1:0] prevData;
    bit            v0, v1;
    int            rem0, rem1;
    logic [DW-1:0] seq0, seq1;

    always #5 clk = ~clk;

    join2_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_0      (dIn0),
        .data_in_1      (dIn1),
        .data_in_valid  (vIn),
        .data_in_ready  (rdy),
        .data_out       (dOut),
        .data_out_valid (vOut),
        .data_out_ready (outRdy)
`ifdef JOIN2_BUFFERED_STATS_EN
        ,
        .skew_max       (skewMax),
        .stall_cycles   (stallCycles)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: records accepted beats, pairs them in order and checks every output handshake.
    always @(negedge clk) begin
        logic [DW-1:0] h0, h1;
        if (!rst_n) begin
            acc0 = 1'b0;
            acc1 = 1'b0;
            prevStall = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            acc0 = vIn[0] && rdy[0];
            acc1 = vIn[1] && rdy[1];
            if (acc0) q0.push_back(dIn0);
            if (acc1) q1.push_back(dIn1);
            if (prevStall) begin
                checkOutput("hold_valid", 64'(vOut), 64'd1);
                checkOutput("hold_data", 64'(dOut), 64'(prevData));
            end
            if (vOut && outRdy) begin
                if (q0.size() == 0 || q1.size() == 0) begin
                    checkOutput("orphan_pair", 64'(vOut), 64'd0);
                end else begin
                    h0 = q0.pop_front();
                    h1 = q1.pop_front();
                    checkOutput("pair", 64'(dOut), 64'({h1, h0}));
                end
            end
            prevStall = vOut && !outRdy;
            prevData  = dOut;
        end
    end

    // One clock of stimulus, entered and left just after a rising edge.
    task automatic applyStimulus(input int pct0, input int pct1, input bit rdyOut, input bit rndData);
        logic [1:0] rSnap;
        if (!v0 && rem0 > 0 && int'($urandom_range(0, 99)) < pct0) begin
            v0 = 1'b1;
            dIn0 = rndData ? DW'($urandom) : seq0;
            seq0++;
            rem0--;
        end
        if (!v1 && rem1 > 0 && int'($urandom_range(0, 99)) < pct1) begin
            v1 = 1'b1;
            dIn1 = rndData ? DW'($urandom) : seq1;
            seq1++;
            rem1--;
        end
        vIn = {v1, v0};
        outRdy = rdyOut;
        #1;
        rSnap = rdy;
        vIn = ~vIn;
        outRdy = ~outRdy;
        #1;
        checkOutput("ready_comb_indep", 64'(rdy), 64'(rSnap));
        vIn = {v1, v0};
        outRdy = rdyOut;
        @(posedge clk);
        #1;
        if (v0 && acc0) v0 = 1'b0;
        if (v1 && acc1) v1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rem0 = 0;
        rem1 = 0;
        while ((q0.size() != 0 || q1.size() != 0 || vOut || v0 || v1) && n < 200) begin
            applyStimulus(0, 0, 1'b1, 1'b0);
            n++;
        end
        checkOutput({name, "_q0_empty"}, 64'(q0.size()), 64'd0);
        checkOutput({name, "_q1_empty"}, 64'(q1.size()), 64'd0);
    endtask

    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        vIn = '0;
        outRdy = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        rem0 = 0;
        rem1 = 0;
        q0.delete();
        q1.delete();
        #1;
        checkOutput("rst_async_valid", 64'(vOut), 64'd0);
        checkOutput("rst_async_data", 64'(dOut), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_release_ready", 64'(rdy), 64'd3);
    endtask

    task automatic runSkew();
        seq0 = 8'hA0;
        rem0 = 4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(100, 0, 1'b1, 1'b0);
            checkOutput("skew_no_out", 64'(vOut), 64'd0);
        end
        checkOutput("skew_ready0_low", 64'(rdy[0]), 64'd0);
        checkOutput("skew_ready1_high", 64'(rdy[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1'b1, 1'b0);
            checkOutput("skew_lone_no_out", 64'(vOut), 64'd0);
        end
        seq1 = 8'hB0;
        rem1 = 4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 100, 1'b1, 1'b0);
        end
        drain("skew");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, nCompared=%0d", nCompared);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0]   b;
        logic [2*DW-1:0] frozen;
        int              cyc;
        v0 = 1'b0; v1 = 1'b0; rem0 = 0; rem1 = 0; seq0 = '0; seq1 = '0;
        frozen = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(vOut), 64'd0);
        checkOutput("reset_data", 64'(dOut), 64'd0);
        checkOutput("reset_ready", 64'(rdy), 64'd3);

        // Balanced stream 0x01..0x08 with two-cycle latency
        $display("[TB] balanced stream");
        seq0 = 8'h01; seq1 = 8'h01; rem0 = 8; rem1 = 8;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(100, 100, 1'b1, 1'b0);
            if (i == 1) begin
                checkOutput("latency_not_early", 64'(vOut), 64'd0);
            end else begin
                b = DW'(i - 1);
                checkOutput("balanced_valid", 64'(vOut), 64'd1);
                checkOutput("balanced_data", 64'(dOut), 64'({b, b}));
            end
        end
        applyStimulus(0, 0, 1'b1, 1'b0);
        checkOutput("balanced_last_data", 64'(dOut), 64'h0808);
        checkOutput("balanced_last_valid", 64'(vOut), 64'd1);
        applyStimulus(0, 0, 1'b1, 1'b0);
        checkOutput("balanced_idle_valid", 64'(vOut), 64'd0);
        drain("balanced");

        // Branch skew
        $display("[TB] skew");
        runSkew();

        // Backpressure for 6 cycles mid-stream
        $display("[TB] backpressure");
        seq0 = 8'h10; seq1 = 8'h10; rem0 = 20; rem1 = 20;
        for (int c = 0; c < 24; c++) begin
            applyStimulus(100, 100, !(c >= 4 && c < 10), 1'b0);
            if (c == 4) frozen = dOut;
            if (c == 9) begin
                checkOutput("bp_ready_low", 64'(rdy), 64'd0);
                checkOutput("bp_frozen", 64'(dOut), 64'(frozen));
                checkOutput("bp_valid", 64'(vOut), 64'd1);
            end
        end
        drain("backpressure");

        // Random valid / ready
        $display("[TB] random traffic");
        rem0 = 1000; rem1 = 1000;
        cyc = 0;
        while ((rem0 > 0 || rem1 > 0 || v0 || v1) && cyc < 20000) begin
            applyStimulus(75, 50, ($urandom_range(0, 3) != 0), 1'b1);
            cyc++;
        end
        checkOutput("random_all_sent", 64'(rem0 + rem1), 64'd0);
        drain("random");

        // Asynchronous reset with three beats buffered per branch
        $display("[TB] reset mid-stream");
        seq0 = 8'h40; seq1 = 8'h50; rem0 = 4; rem1 = 4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(100, 100, 1'b0, 1'b0);
        end
        checkOutput("mid_valid_before", 64'(vOut), 64'd1);
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1'b1, 1'b0);
            checkOutput("mid_after_valid", 64'(vOut), 64'd0);
        end
        seq0 = 8'h60; seq1 = 8'h70; rem0 = 2; rem1 = 2;
        applyStimulus(100, 100, 1'b1, 1'b0);
        applyStimulus(100, 100, 1'b1, 1'b0);
        checkOutput("mid_fresh_valid", 64'(vOut), 64'd1);
        checkOutput("mid_fresh_data", 64'(dOut), 64'h7060);
        drain("mid_reset");

`ifdef JOIN2_BUFFERED_STATS_EN
        $display("[TB] stats");
        pulseReset();
        checkOutput("stats_skew_reset", 64'(skewMax), 64'd0);
        checkOutput("stats_stall_reset", 64'(stallCycles), 64'd0);
        runSkew();
        checkOutput("stats_skew_max", 64'(skewMax), 64'd4);
        checkOutput("stats_stall_none", 64'(stallCycles), 64'd0);
        seq0 = 8'h90; seq1 = 8'h91; rem0 = 1; rem1 = 1;
        applyStimulus(100, 100, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("stats_out_valid", 64'(vOut), 64'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1'b0, 1'b0);
        end
        checkOutput("stats_stall_cycles", 64'(stallCycles), 64'd5);
        drain("stats");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
